// File: rtl/pe_mac_sequencer.sv
// Sequences a small tap buffer through an external single-cycle MAC PE and returns the
// accumulated dot product over a valid/ready handshake.
module pe_mac_sequencer #(
  parameter int unsigned XW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned BW    = 20,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ld_en,
  input  logic [AW-1:0]        i_ld_addr,
  input  logic signed [XW-1:0] i_ld_x,
  input  logic signed [WW-1:0] i_ld_w,
  input  logic                 i_start,
  input  logic [AW:0]          i_len,
  output logic signed [XW-1:0] o_pe_x,
  output logic signed [WW-1:0] o_pe_w,
  output logic signed [BW-1:0] o_pe_psum,
  input  logic signed [BW-1:0] i_pe_psum,
  output logic                 o_busy,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [BW-1:0] o_result
);

  localparam logic [AW:0] DepthL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] OneL   = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StHold} state_e;

  state_e                state_q, state_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [AW:0]           len_q, len_d;
  logic signed [BW-1:0]  result_q, result_d;
  logic signed [XW-1:0]  x_q [DEPTH];
  logic signed [WW-1:0]  w_q [DEPTH];
  logic [AW:0]           eff_len;

  assign eff_len = (i_len > DepthL) ? DepthL : i_len;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    result_d  = result_q;
    o_pe_x    = '0;
    o_pe_w    = '0;
    o_pe_psum = '0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          len_d   = eff_len;
          cnt_d   = '0;
          state_d = (eff_len == '0) ? StDrain : StFeed;
        end
      end
      StFeed: begin
        o_pe_x    = x_q[cnt_q[AW-1:0]];
        o_pe_w    = w_q[cnt_q[AW-1:0]];
        // First tap seeds the PE with zero; later taps chain its registered output.
        o_pe_psum = (cnt_q == '0) ? '0 : i_pe_psum;
        if (cnt_q == len_q - OneL) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + OneL;
        end
      end
      StDrain: begin
        result_d = i_pe_psum;
        state_d  = StHold;
      end
      StHold: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      result_q <= result_d;
    end
  end

  // Loads are only honoured in IDLE so a running dot product never sees a torn buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (state_q == StIdle && i_ld_en && (int'(i_ld_addr) < int'(DEPTH))) begin
      x_q[i_ld_addr] <= i_ld_x;
      w_q[i_ld_addr] <= i_ld_w;
    end
  end

  assign o_busy   = (state_q != StIdle);
  assign o_valid  = (state_q == StHold);
  assign o_result = result_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench: behavioural PE, shadow tap buffer and a result scoreboard.
module tb_pe_mac_sequencer;

  localparam int unsigned XW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned BW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic                 clk;
  logic                 rst_n;
  logic                 ld_en;
  logic [AW-1:0]        ld_addr;
  logic signed [XW-1:0] ld_x;
  logic signed [WW-1:0] ld_w;
  logic                 start;
  logic [AW:0]          len;
  logic signed [XW-1:0] pe_x;
  logic signed [WW-1:0] pe_w;
  logic signed [BW-1:0] pe_psum_in;
  logic signed [BW-1:0] pe_q;
  logic                 busy;
  logic                 valid;
  logic                 ready;
  logic signed [BW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [XW-1:0] sx [DEPTH];
  logic signed [WW-1:0] sw [DEPTH];
  longint exp_q [$];

  pe_mac_sequencer #(
    .XW   (XW),
    .WW   (WW),
    .BW   (BW),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ld_en  (ld_en),
    .i_ld_addr(ld_addr),
    .i_ld_x   (ld_x),
    .i_ld_w   (ld_w),
    .i_start  (start),
    .i_len    (len),
    .o_pe_x   (pe_x),
    .o_pe_w   (pe_w),
    .o_pe_psum(pe_psum_in),
    .i_pe_psum(pe_q),
    .o_busy   (busy),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered MAC PE with one cycle of latency.
  always_ff @(posedge clk) begin
    pe_q <= pe_psum_in + pe_x * pe_w;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int eff);
    logic signed [BW-1:0] acc;
    acc = '0;
    for (int i = 0; i < eff; i++) acc = acc + sx[i] * sw[i];
    return longint'(acc);
  endfunction

  task automatic clear_shadow();
    for (int i = 0; i < int'(DEPTH); i++) begin
      sx[i] = '0;
      sw[i] = '0;
    end
  endtask

  task automatic load(input int addr, input int x, input int w);
    ld_en   = 1'b1;
    ld_addr = AW'(addr);
    ld_x    = XW'(x);
    ld_w    = WW'(w);
    sx[addr] = XW'(x);
    sw[addr] = WW'(w);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Starts a run from IDLE; hold_n > 0 keeps ready low that many HOLD cycles while
  // pulsing start and loads that must be ignored.
  task automatic run(input int run_len, input int hold_n);
    int     eff;
    int     lat;
    longint r0;
    eff = (run_len > int'(DEPTH)) ? int'(DEPTH) : run_len;
    exp_q.push_back(model(eff));
    ready = (hold_n == 0);
    start = 1'b1;
    len   = (AW + 1)'(run_len);
    @(posedge clk); #1;
    start = 1'b0;
    ld_en = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
      check_eq("busy_in_run", longint'(busy), 1);
      @(posedge clk); #1;
    end
    check_eq("valid_latency", lat, eff + 2);
    if (lat == 0) return;
    check_eq("busy_at_valid", longint'(busy), 1);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      return;
    end
    check_eq("result", longint'(result), exp_q.pop_front());
    r0 = longint'(result);
    for (int h = 0; h < hold_n; h++) begin
      @(posedge clk); #1;
      start   = h[0];
      len     = (AW + 1)'(1);
      ld_en   = ~h[0];
      ld_addr = '0;
      ld_x    = 8'sd99;
      ld_w    = 8'sd99;
      @(negedge clk);
      check_eq("hold_valid", longint'(valid), 1);
      check_eq("hold_result", longint'(result), r0);
    end
    if (hold_n > 0) begin
      @(posedge clk); #1;
      ld_en = 1'b0;
      ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check_eq("handshake_valid", longint'(valid), 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("post_valid", longint'(valid), 0);
    check_eq("post_busy", longint'(busy), 0);
    check_eq("post_result_kept", longint'(result), r0);
    check_eq("idle_pe_psum", longint'(pe_psum_in), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen_valid;
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_x = '0; ld_w = '0;
    start = 1'b0; len = '0; ready = 1'b1;
    clear_shadow();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_valid", longint'(valid), 0);
    check_eq("rst_result", longint'(result), 0);
    check_eq("rst_pe_x", longint'(pe_x), 0);
    check_eq("rst_pe_psum", longint'(pe_psum_in), 0);
    @(posedge clk); #1;

    load(0, 1, 4); load(1, 2, 5); load(2, 3, 6);
    run(3, 0);

    load(0, -3, 7);
    run(1, 0);
    run(0, 0);

    for (int i = 0; i < int'(DEPTH); i++) load(i, -128, -128);
    run(8, 0);
    run(12, 0);

    for (int i = 0; i < int'(DEPTH); i++) load(i, i - 3, 2 * i + 1);
    run(4, 10);
    run(4, 0);

    // Write and start in the same IDLE cycle: the write must be seen by tap 1.
    ld_en = 1'b1; ld_addr = AW'(1); ld_x = 8'sd5; ld_w = -8'sd9;
    sx[1] = 8'sd5; sw[1] = -8'sd9;
    run(2, 0);

    // Reset during FEED tap 2 of a len 5 run.
    for (int i = 0; i < 5; i++) load(i, i + 1, 1);
    start = 1'b1; len = (AW + 1)'(5);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("feed_tap2_x", longint'(pe_x), longint'(sx[2]));
    check_eq("feed_tap2_psum", longint'(pe_psum_in), 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_shadow();
    @(negedge clk);
    check_eq("abort_busy", longint'(busy), 0);
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid) seen_valid = 1;
      @(negedge clk);
    end
    check_eq("abort_no_valid", seen_valid, 0);
    @(posedge clk); #1;
    load(0, 0, 0);
    clear_shadow();
    run(1, 0);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < int'(DEPTH); i++)
        load(i, int'($signed(8'($urandom_range(0, 255)))),
             int'($signed(8'($urandom_range(0, 255)))));
      run(int'($urandom_range(0, 10)), 0);
    end

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
